// File: rtl/div_by_3_sched.sv
// div_by_3_sched: round-robin scheduler sharing one serial divisible-by-3
// checker among N_REQ parallel-word requesters. A granted word is captured,
// the checker is cleared for one cycle, the word is shifted in MSB-first,
// and the checker's divl output is sampled and returned tagged with the
// requester ID.
//
// Handshake: a requester holds req[i] high with a stable word; the word is
// captured at the accepting edge and ack[i] pulses for one cycle afterwards.
// The requester drops req[i] on seeing ack[i]; a req still high at the next
// IDLE cycle counts as a new request. res_valid is a one-cycle pulse with no
// back-pressure; res_div/res_id hold until the next result or reset.
//
// Optional build macro DIV_BY_3_SCHED_SELF_CHECK_EN adds a local modulo-3
// accumulator and a sticky chk_err output that flags checker disagreement.
module div_by_3_sched #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] word,
    output logic [N_REQ-1:0]       ack,
    output logic                   chk_res_n,
    output logic                   chk_bit,
    input  logic                   chk_divl,
    output logic                   res_valid,
    output logic                   res_div,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy
`ifdef DIV_BY_3_SCHED_SELF_CHECK_EN
    ,
    output logic                   chk_err
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLR    = 2'd1,
        S_SHIFT  = 2'd2,
        S_SAMPLE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [WIDTH-1:0] r_sreg;
    logic [ID_W-1:0]  r_cur_id;
    logic [CNT_W-1:0] r_cnt;
    logic [N_REQ-1:0] r_ack;
    logic             r_res_valid;
    logic             r_res_div;
    logic [ID_W-1:0]  r_res_id;

    logic             w_found;
    logic [ID_W-1:0]  w_winner;
    logic [ID_W-1:0]  w_rr_next;
    logic             w_chk_res_n;
    logic             w_chk_bit;

    // Round-robin arbiter: first set request searching upward from r_rr_ptr.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req[(int'(r_rr_ptr) + i) % N_REQ]) begin
                w_found  = 1'b1;
                w_winner = ID_W'((int'(r_rr_ptr) + i) % N_REQ);
            end
        end
        w_rr_next = (w_winner == ID_W'(N_REQ - 1)) ? '0 : w_winner + ID_W'(1);
    end

    // Next-state logic and checker drive; the checker is held cleared outside SHIFT/SAMPLE.
    always_comb begin
        w_next_state = r_state;
        w_chk_res_n  = 1'b0;
        w_chk_bit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_next_state = S_CLR;
            end
            S_CLR: begin
                w_next_state = S_SHIFT;
            end
            S_SHIFT: begin
                w_chk_res_n = 1'b1;
                w_chk_bit   = r_sreg[WIDTH-1];
                if (r_cnt == CNT_W'(WIDTH - 1)) w_next_state = S_SAMPLE;
            end
            S_SAMPLE: begin
                w_chk_res_n  = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register and datapath: capture, shift, and result sampling.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_sreg      <= '0;
            r_cur_id    <= '0;
            r_cnt       <= '0;
            r_ack       <= '0;
            r_res_valid <= 1'b0;
            r_res_div   <= 1'b0;
            r_res_id    <= '0;
        end else begin
            r_state     <= w_next_state;
            r_ack       <= '0;
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_sreg   <= word[int'(w_winner)*WIDTH +: WIDTH];
                        r_cur_id <= w_winner;
                        r_ack    <= N_REQ'(1) << w_winner;
                        r_rr_ptr <= w_rr_next;
                    end
                end
                S_CLR: begin
                    r_cnt <= '0;
                end
                S_SHIFT: begin
                    r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                S_SAMPLE: begin
                    r_res_div   <= chk_divl;
                    r_res_id    <= r_cur_id;
                    r_res_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_BY_3_SCHED_SELF_CHECK_EN
    logic [1:0] r_rem;
    logic [1:0] w_rem_next;
    logic       r_chk_err;

    // Local remainder: rem' = (2*rem + bit) mod 3.
    always_comb begin
        w_rem_next = 2'd0;
        case ({r_rem, w_chk_bit})
            3'b00_0: w_rem_next = 2'd0;
            3'b00_1: w_rem_next = 2'd1;
            3'b01_0: w_rem_next = 2'd2;
            3'b01_1: w_rem_next = 2'd0;
            3'b10_0: w_rem_next = 2'd1;
            3'b10_1: w_rem_next = 2'd2;
            default: w_rem_next = 2'd0;
        endcase
    end

    // Accumulate during SHIFT and raise a sticky error if the checker disagrees at SAMPLE.
    always_ff @(posedge clk) begin
        if (res) begin
            r_rem     <= 2'd0;
            r_chk_err <= 1'b0;
        end else begin
            case (r_state)
                S_CLR:    r_rem <= 2'd0;
                S_SHIFT:  r_rem <= w_rem_next;
                S_SAMPLE: if (chk_divl != (r_rem == 2'd0)) r_chk_err <= 1'b1;
                default:  ;
            endcase
        end
    end

    assign chk_err = r_chk_err;
`endif

    assign ack       = r_ack;
    assign chk_res_n = w_chk_res_n;
    assign chk_bit   = w_chk_bit;
    assign res_valid = r_res_valid;
    assign res_div   = r_res_div;
    assign res_id    = r_res_id;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_div_by_3_sched.sv
// Bench for div_by_3_sched (N_REQ=4, WIDTH=8) with a behavioural serial
// divisible-by-3 checker attached to the checker ports.
module tb_div_by_3_sched;

  logic        clk = 1'b0;
  logic        res;
  logic [3:0]  req;
  logic [31:0] word;
  logic [3:0]  ack;
  logic        chk_res_n;
  logic        chk_bit;
  logic        chk_divl;
  logic        res_valid;
  logic        res_div;
  logic [1:0]  res_id;
  logic        busy;
`ifdef DIV_BY_3_SCHED_SELF_CHECK_EN
  logic        chk_err;
`endif

  int errors = 0;
  int checks = 0;

  // behavioural checker: synchronous active-low clear, Moore divl
  logic [1:0] m_rem;
  logic       stuck = 1'b0;

  div_by_3_sched #(.N_REQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .res       (res),
    .req       (req),
    .word      (word),
    .ack       (ack),
    .chk_res_n (chk_res_n),
    .chk_bit   (chk_bit),
    .chk_divl  (chk_divl),
    .res_valid (res_valid),
    .res_div   (res_div),
    .res_id    (res_id),
    .busy      (busy)
`ifdef DIV_BY_3_SCHED_SELF_CHECK_EN
    ,
    .chk_err   (chk_err)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!chk_res_n) m_rem <= 2'd0;
    else            m_rem <= 2'((int'(m_rem) * 2 + int'(chk_bit)) % 3);
  end
  assign chk_divl = stuck ? 1'b1 : (m_rem == 2'd0);

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic do_reset();
    res = 1'b1;
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    res = 1'b0;
  endtask

  // present one word on requester id, drop req on ack, wait for the result
  task automatic send(input int id, input logic [7:0] w,
                      output logic [3:0] got_ack, output logic got_clr,
                      output logic [7:0] got_bits, output int res_cyc,
                      output logic got_div, output logic [1:0] got_id);
    word[id*8 +: 8] = w;
    req[id] = 1'b1;
    @(posedge clk); #1;
    got_ack  = ack;
    got_clr  = chk_res_n;
    req      = req & ~ack;
    word[id*8 +: 8] = ~w;
    got_bits = 8'd0;
    res_cyc  = -1;
    got_div  = 1'b0;
    got_id   = 2'd0;
    for (int c = 2; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c <= 9) got_bits = {got_bits[6:0], chk_bit};
      if (res_valid) begin
        res_cyc = c;
        got_div = res_div;
        got_id  = res_id;
        break;
      end
    end
  endtask

  task automatic test_reset();
    word = 32'd0;
    do_reset();
    checks++; if (ack !== 4'b0000)   begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    checks++; if (res_div !== 1'b0)  begin errors++; $display("FAIL reset_res_div: got %b expected 0", res_div); end
    checks++; if (res_id !== 2'd0)   begin errors++; $display("FAIL reset_res_id: got %0d expected 0", res_id); end
    checks++; if (chk_bit !== 1'b0)  begin errors++; $display("FAIL reset_chk_bit: got %b expected 0", chk_bit); end
    checks++; if (chk_res_n !== 1'b0) begin errors++; $display("FAIL reset_chk_res_n: got %b expected 0", chk_res_n); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_words();
    logic [7:0] words [5] = '{8'd9, 8'd10, 8'd0, 8'd255, 8'd254};
    logic       exp_d [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int         ids   [5] = '{0, 1, 2, 3, 0};
    logic [3:0] g_ack;
    logic       g_clr, g_div;
    logic [7:0] g_bits;
    logic [1:0] g_id;
    int         g_cyc;
    logic [3:0] exp_ack;
    for (int k = 0; k < 5; k++) begin
      send(ids[k], words[k], g_ack, g_clr, g_bits, g_cyc, g_div, g_id);
      exp_ack = 4'(1 << ids[k]);
      checks++; if (g_ack !== exp_ack) begin errors++; $display("FAIL single_ack[%0d]: got %b expected %b", k, g_ack, exp_ack); end
      checks++; if (g_clr !== 1'b0) begin errors++; $display("FAIL single_clr[%0d]: chk_res_n got %b expected 0", k, g_clr); end
      checks++; if (g_bits !== words[k]) begin errors++; $display("FAIL single_bits[%0d]: got %b expected %b", k, g_bits, words[k]); end
      checks++; if (g_cyc != 11) begin errors++; $display("FAIL single_latency[%0d]: got %0d expected 11", k, g_cyc); end
      checks++; if (g_div !== exp_d[k]) begin errors++; $display("FAIL single_div[%0d]: got %b expected %b", k, g_div, exp_d[k]); end
      checks++; if (g_id !== 2'(ids[k])) begin errors++; $display("FAIL single_id[%0d]: got %0d expected %0d", k, g_id, ids[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_q [$];
    logic       exp_d [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int         grant_ids [5] = '{0, 1, 2, 3, 0};
    int         na = 0;
    int         nr = 0;
    logic [1:0] e_id;
    logic [3:0] exp_ack;
    do_reset();
    word = {8'd6, 8'd5, 8'd4, 8'd3};
    req  = 4'b1111;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (ack !== 4'b0000) begin
        if (na < 5) begin
          exp_ack = 4'(1 << grant_ids[na]);
          checks++; if (ack !== exp_ack) begin errors++; $display("FAIL b2b_ack[%0d]: got %b expected %b", na, ack, exp_ack); end
          checks++; if (c != 1 + 11 * na) begin errors++; $display("FAIL b2b_ack_cycle[%0d]: got %0d expected %0d", na, c, 1 + 11 * na); end
          exp_q.push_back(2'(grant_ids[na]));
        end else begin
          errors++; checks++; $display("FAIL b2b_extra_ack: got %b expected 0000", ack);
        end
        na++;
        if (na == 5) req = 4'b0000;
      end
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          errors++; checks++; $display("FAIL b2b_unexpected_result: got id %0d expected none", res_id);
        end else begin
          e_id = exp_q.pop_front();
          checks++; if (res_id !== e_id) begin errors++; $display("FAIL b2b_id[%0d]: got %0d expected %0d", nr, res_id, e_id); end
          checks++; if (res_div !== exp_d[nr]) begin errors++; $display("FAIL b2b_div[%0d]: got %b expected %b", nr, res_div, exp_d[nr]); end
          checks++; if (c != 11 * (nr + 1)) begin errors++; $display("FAIL b2b_res_cycle[%0d]: got %0d expected %0d", nr, c, 11 * (nr + 1)); end
        end
        nr++;
        if (nr == 5) break;
      end
    end
    req = 4'b0000;
    checks++; if (na != 5) begin errors++; $display("FAIL b2b_grant_count: got %0d expected 5", na); end
    checks++; if (nr != 5) begin errors++; $display("FAIL b2b_result_count: got %0d expected 5", nr); end
  endtask

  task automatic test_round_robin();
    logic [3:0] g_ack;
    logic       g_clr, g_div;
    logic [7:0] g_bits;
    logic [1:0] g_id;
    int         g_cyc;
    int         na = 0;
    int         nr = 0;
    logic [3:0] exp_ack [2] = '{4'b1000, 4'b0010};
    logic [1:0] exp_id  [2] = '{2'd3, 2'd1};
    logic       exp_d   [2] = '{1'b0, 1'b1};
    do_reset();
    // a lone grant to requester 1 leaves the pointer at 2
    send(1, 8'd12, g_ack, g_clr, g_bits, g_cyc, g_div, g_id);
    checks++; if (g_ack !== 4'b0010) begin errors++; $display("FAIL rr_setup_ack: got %b expected 0010", g_ack); end
    checks++; if (g_div !== 1'b1) begin errors++; $display("FAIL rr_setup_div: got %b expected 1", g_div); end
    word[15:8]  = 8'd9;
    word[31:24] = 8'd7;
    req = 4'b1010;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ack !== 4'b0000) begin
        if (na < 2) begin
          checks++; if (ack !== exp_ack[na]) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", na, ack, exp_ack[na]); end
        end
        req = req & ~ack;
        na++;
      end
      if (res_valid) begin
        if (nr < 2) begin
          checks++; if (res_id !== exp_id[nr]) begin errors++; $display("FAIL rr_id[%0d]: got %0d expected %0d", nr, res_id, exp_id[nr]); end
          checks++; if (res_div !== exp_d[nr]) begin errors++; $display("FAIL rr_div[%0d]: got %b expected %b", nr, res_div, exp_d[nr]); end
        end
        nr++;
        if (nr == 2) break;
      end
    end
    checks++; if (nr != 2) begin errors++; $display("FAIL rr_result_count: got %0d expected 2", nr); end
    // pointer should now be 2: with all requesting, requester 2 wins
    req = 4'b1111;
    @(posedge clk); #1;
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL rr_ptr_after: ack got %b expected 0100", ack); end
    req = 4'b0000;
    for (int c = 2; c <= 30; c++) begin
      @(posedge clk); #1;
      if (res_valid) break;
    end
  endtask

  task automatic test_abort();
    logic [3:0] g_ack;
    logic       g_clr, g_div;
    logic [7:0] g_bits;
    logic [1:0] g_id;
    int         g_cyc;
    logic       saw_valid = 1'b0;
    do_reset();
    word[7:0] = 8'd9;
    req = 4'b0001;
    @(posedge clk); #1;
    req = 4'b0000;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
    res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b expected 0", busy); end
    checks++; if (chk_res_n !== 1'b0) begin errors++; $display("FAIL abort_chk_res_n: got %b expected 0", chk_res_n); end
    for (int c = 0; c < 20; c++) begin
      if (res_valid === 1'b1 || ack !== 4'b0000) saw_valid = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result: activity got %b expected 0", saw_valid); end
    send(0, 8'd6, g_ack, g_clr, g_bits, g_cyc, g_div, g_id);
    checks++; if (g_ack !== 4'b0001) begin errors++; $display("FAIL abort_next_ack: got %b expected 0001", g_ack); end
    checks++; if (g_cyc != 11) begin errors++; $display("FAIL abort_next_latency: got %0d expected 11", g_cyc); end
    checks++; if (g_div !== 1'b1) begin errors++; $display("FAIL abort_next_div: got %b expected 1", g_div); end
  endtask

`ifdef DIV_BY_3_SCHED_SELF_CHECK_EN
  task automatic test_self_check();
    logic [3:0] g_ack;
    logic       g_clr, g_div;
    logic [7:0] g_bits;
    logic [1:0] g_id;
    int         g_cyc;
    do_reset();
    checks++; if (chk_err !== 1'b0) begin errors++; $display("FAIL selfchk_reset: got %b expected 0", chk_err); end
    stuck = 1'b1;
    send(0, 8'd10, g_ack, g_clr, g_bits, g_cyc, g_div, g_id);
    stuck = 1'b0;
    checks++; if (chk_err !== 1'b1) begin errors++; $display("FAIL selfchk_flag: got %b expected 1", chk_err); end
    send(1, 8'd9, g_ack, g_clr, g_bits, g_cyc, g_div, g_id);
    checks++; if (chk_err !== 1'b1) begin errors++; $display("FAIL selfchk_sticky: got %b expected 1", chk_err); end
    do_reset();
    checks++; if (chk_err !== 1'b0) begin errors++; $display("FAIL selfchk_clear: got %b expected 0", chk_err); end
  endtask
`endif

  initial begin
    res  = 1'b0;
    req  = 4'b0000;
    word = 32'd0;
    test_reset();
    test_single_words();
    test_back_to_back();
    test_round_robin();
    test_abort();
`ifdef DIV_BY_3_SCHED_SELF_CHECK_EN
    test_self_check();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_by_3_sched.md
Name: div_by_3_sched

Overview:
Round-robin scheduler that shares one serial divisible-by-3 checker (ports res_n, bit_number, divl) among N_REQ parallel-word requesters. It accepts one word at a time, clears the checker, and shifts the word in MSB-first. It then samples the checker's divl output and returns the verdict tagged with the requester ID. It sits between the requester interfaces and the div_by_3 instance and owns all of that instance's control inputs.

Parameters:
N_REQ, 4, number of requesters (>=2)
WIDTH, 8, bits per word (>=2)
ID_W, $clog2(N_REQ), localparam, width of requester ID

Ports:
clk  in  1  system clock, rising edge
res  in  1  synchronous, active-high reset
req  in  N_REQ  level request per requester
word  in  N_REQ*WIDTH  flattened words; requester i at [i*WIDTH +: WIDTH]
ack  out  N_REQ  one-hot, one-cycle pulse: word of requester i captured
chk_res_n  out  1  drives checker res_n (active-low clear)
chk_bit  out  1  drives checker bit_number
chk_divl  in  1  checker divl (Moore output, reflects all bits clocked so far)
res_valid  out  1  one-cycle pulse: result available
res_div  out  1  1 = word divisible by 3
res_id  out  ID_W  requester that owns the result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (res=1 at a clk edge):
  - state=IDLE, rr_ptr=0.
  - ack=0, res_valid=0, res_div=0, res_id=0, chk_bit=0, chk_res_n=0, busy=0.
  - Reset mid-operation aborts the word with no res_valid and no re-request. Takes precedence over all other events.
- FSM states: IDLE, CLR, SHIFT, SAMPLE.
- IDLE:
  - chk_res_n=0, chk_bit=0.
  - If req!=0, the winner is the first set bit searching upward from rr_ptr, wrapping at N_REQ.
  - At the edge: capture the winner's word into sreg, winner into cur_id, set ack[winner]=1 for the next cycle, rr_ptr<=(winner+1) mod N_REQ, go to CLR.
- CLR: one cycle, chk_res_n=0, chk_bit=0 (guaranteed checker clear). Go to SHIFT with cnt=0.
- SHIFT: WIDTH cycles.
  - chk_res_n=1, chk_bit=sreg[WIDTH-1].
  - Each edge: sreg shifts left by one, cnt++.
  - When cnt==WIDTH-1, go to SAMPLE.
- SAMPLE: one cycle, chk_res_n=1, chk_bit=0.
  - At the edge: res_div<=chk_divl, res_id<=cur_id, res_valid<=1, go to IDLE.
- Timing (accept cycle = 0):
  - ack high in cycle 1.
  - Bits presented in cycles 2..WIDTH+1.
  - res_valid high in cycle WIDTH+3, which is an IDLE cycle; a new request can be accepted that same cycle.
  - Back-to-back throughput is one word per WIDTH+3 cycles.
- req is sampled only in IDLE. A req still high at the next IDLE is a new request; requesters drop req upon seeing ack.
- Changes to word after ack have no effect on the result.
- res_div and res_id hold their values until the next SAMPLE or reset; res_valid is a pulse.
- Simultaneous requests resolve by round-robin only; no starvation. Worst-case wait is (N_REQ-1)*(WIDTH+3) cycles.
- rr_ptr wraps from N_REQ-1 to 0.

Optional Feature:
- Macro: DIV_BY_3_SCHED_SELF_CHECK_EN.
- When defined:
  - Adds output chk_err (1 bit, reset 0).
  - An internal modulo-3 accumulator runs alongside SHIFT: rem<=(2*rem+bit) mod 3, cleared in CLR.
  - In SAMPLE, if chk_divl != (rem==0), chk_err<=1. chk_err is sticky until reset.
- When undefined: no chk_err port and no accumulator logic; all other behaviour is identical.

Test Plan:
- N_REQ=4, WIDTH=8. Reset, then req=4'b0001 with word0=8'd9 -> ack=4'b0001 in cycle 1; res_valid in cycle 11 with res_div=1, res_id=0.
- Single requests with word=8'd10, 8'd0, 8'd255, 8'd254 -> res_div=0, 1, 1, 0 respectively.
- req=4'b1111 held high, words 3,4,5,6 -> grants in order 0,1,2,3,0; res_valid every 11 cycles; res_div sequence 1,0,0,1.
- req=4'b1010 after rr_ptr=2 -> grant 3 first, then 1; rr_ptr=2 after the second grant.
- Assert res for one cycle in the 4th SHIFT cycle -> next cycle busy=0, chk_res_n=0, no res_valid for the aborted word. A subsequent word0=8'd6 gives res_div=1.
- DIV_BY_3_SCHED_SELF_CHECK_EN defined, checker model stuck divl=1, word=8'd10 -> chk_err=1 after SAMPLE and stays 1 through later correct words until reset.
